// File: rtl/spi_tgt_pkg.sv
// spi_tgt_pkg -- shared types and constants for the SPI target register block.
//   state_t        : frame FSM states (IDLE, CMD, WR, RD)
//   CMD_RW_BIT     : command byte bit selecting read (1) or write (0)
//   CMD_ADDR_W     : width of the address field in the command byte
//   DEFAULT_NREGS  : default register count
package spi_tgt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } state_t;

    localparam int CMD_RW_BIT    = 7;
    localparam int CMD_ADDR_W    = 7;
    localparam int DEFAULT_NREGS = 16;

endpackage

// File: rtl/spi_tgt_if.sv
// spi_tgt_if -- SPI mode-0 link between a host (master) and the register target (slave).
//   spi_sclk    : serial clock, driven by the host
//   spi_cs_n    : chip select, active-low, driven by the host
//   spi_mosi    : host -> target data
//   spi_miso    : target -> host data
//   spi_miso_oe : target pad output enable, high while the target owns the frame
interface spi_tgt_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );

endinterface

// File: rtl/spi_tgt_sync.sv
// spi_tgt_sync -- multi-flop synchronizer for one asynchronous input plus edge detect.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized level
//   rise     : one-cycle pulse when q goes 0 -> 1
//   fall     : one-cycle pulse when q goes 1 -> 0
// Parameters: SYNC = synchronizer depth (>= 2), RST_VAL = value all flops take in reset,
// chosen to match the line's idle level so that reset release creates no false edge.
module spi_tgt_sync #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] chain;
    logic            q_d;

    // NOTE: clocked state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC{RST_VAL}};
            q_d   <= RST_VAL;
        end else begin
            chain <= {chain[SYNC-2:0], d};
            q_d   <= chain[SYNC-1];
        end
    end

    assign q    = chain[SYNC-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_tgt_regs.sv
// spi_tgt_regs -- SPI mode-0 target exposing NREGS byte registers to an external host.
//   clk, rst   : system clock, asynchronous active-high reset
//   spi        : spi_tgt_if slave modport (sclk/cs_n/mosi oversampled in clk domain)
//   lcl_we     : one-cycle local write strobe
//   lcl_addr   : local write address
//   lcl_wdata  : local write data
//   regs_o     : flat register contents, reg i at [8*i+7:8*i]
//   wr_irq     : only when SPI_TGT_IRQ_EN is defined; one-cycle pulse after a frame
//                that wrote at least one data byte
// Frame: command byte {rw, addr[6:0]} then any number of data bytes, MSB first;
// the address auto-increments after each data byte, modulo NREGS.
module spi_tgt_regs
    import spi_tgt_pkg::*;
#(
    parameter int  NREGS = DEFAULT_NREGS,
    parameter int  SYNC  = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    spi_tgt_if.slave           spi,
    input  logic               lcl_we,
    input  logic [AW-1:0]      lcl_addr,
    input  logic [7:0]         lcl_wdata,
    output logic [8*NREGS-1:0] regs_o
`ifdef SPI_TGT_IRQ_EN
    ,
    output logic               wr_irq
`endif
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_tgt_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi.spi_sclk),
        .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_tgt_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi.spi_cs_n),
        .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_tgt_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi.spi_mosi),
        .q(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    // The cs_n synchronizer is preset high, so a CS already low at reset release
    // would surface as a cs_fall. Frames are only accepted once the pipeline has
    // flushed and CS has been seen high.
    localparam int                WARM_W    = $clog2(SYNC + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC + 1);

    logic [WARM_W-1:0] warm_cnt;
    logic              cs_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= '0;
            cs_armed <= 1'b0;
        end else if (warm_cnt != WARM_DONE) begin
            warm_cnt <= warm_cnt + 1'b1;
        end else if (cs_lvl) begin
            cs_armed <= 1'b1;
        end
    end

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_sr;
    logic [7:0]    rx_byte;
    logic [AW-1:0] addr;
    logic [7:0]    tx_sr;
    logic          byte_done;
    logic          spi_we;
    logic [7:0]    regs [NREGS];

    // Byte being completed by the current rise, including the bit on mosi now.
    assign rx_byte = {rx_sr, mosi_lvl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        byte_done = 1'b0;
        spi_we    = 1'b0;
        if (state != IDLE && !cs_rise && sclk_rise && bit_cnt == 3'd7) byte_done = 1'b1;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall && cs_armed) state_nxt = CMD;
                CMD:     if (byte_done) state_nxt = rx_byte[CMD_RW_BIT] ? RD : WR;
                WR:      spi_we = byte_done;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
            addr    <= '0;
            tx_sr   <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            tx_sr   <= '0;
        end else if (!cs_rise) begin
            if (sclk_rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) addr <= (state == CMD) ? rx_byte[AW-1:0] : addr + 1'b1;
            // The byte is captured at load time, so later writes cannot disturb it.
            if (state == RD && sclk_fall)
                tx_sr <= (bit_cnt == 3'd0) ? regs[addr] : {tx_sr[6:0], 1'b0};
        end
    end

    // NOTE: the register file is explicitly cleared in reset because software
    // relies on reading zeros from every register after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (lcl_we) regs[lcl_addr] <= lcl_wdata;
            // Later assignment wins, so the SPI write takes priority on a clash.
            if (spi_we) regs[addr] <= rx_byte;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs[g];
    end

    assign spi.spi_miso_oe = (state != IDLE);
    assign spi.spi_miso    = (state != IDLE) & tx_sr[7];

`ifdef SPI_TGT_IRQ_EN
    logic frame_wrote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_wrote <= 1'b0;
            wr_irq      <= 1'b0;
        end else begin
            wr_irq <= cs_rise & frame_wrote;
            if (cs_rise)     frame_wrote <= 1'b0;
            else if (spi_we) frame_wrote <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_tgt_regs.sv
// tb_spi_tgt_regs -- self-checking bench for spi_tgt_regs.
// A byte-array register model is updated at frame/byte granularity; a compare
// process checks regs_o, miso_oe and idle miso against it on every quiet cycle.
module tb_spi_tgt_regs;

    localparam int NREGS = 16;
    localparam int SYNC  = 2;
    localparam int HALF  = 5;
    localparam int FW    = 8 * NREGS;

    logic          clk = 1'b0;
    logic          rst;
    logic          lcl_we;
    logic [3:0]    lcl_addr;
    logic [7:0]    lcl_wdata;
    logic [FW-1:0] regs_o;
`ifdef SPI_TGT_IRQ_EN
    logic          wr_irq;
`endif

    spi_tgt_if bus ();

    always #5 clk = ~clk;

    spi_tgt_regs #(.NREGS(NREGS), .SYNC(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (bus),
        .lcl_we   (lcl_we),
        .lcl_addr (lcl_addr),
        .lcl_wdata(lcl_wdata),
        .regs_o   (regs_o)
`ifdef SPI_TGT_IRQ_EN
        ,
        .wr_irq   (wr_irq)
`endif
    );

    int         n_chk = 0;
    int         n_bad = 0;
    logic [7:0] model  [NREGS];
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    bit         settled = 1'b0;
    bit         exp_oe  = 1'b0;
    int         irq_seen = 0;
    int         irq_exp  = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: quiet cycles only (no edge or write in flight).
    always @(negedge clk) begin
        if (!rst && settled) begin
            check("regs_o", regs_o, model_flat());
            check("miso_oe", FW'(bus.spi_miso_oe), FW'(exp_oe));
            if (!exp_oe) check("miso_idle", FW'(bus.spi_miso), '0);
        end
`ifdef SPI_TGT_IRQ_EN
        if (!rst && wr_irq === 1'b1) irq_seen++;
`endif
    end

    task automatic lcl_write(input logic [3:0] a, input logic [7:0] d);
        settled   = 1'b0;
        lcl_we    = 1'b1;
        lcl_addr  = a;
        lcl_wdata = d;
        tick(1);
        lcl_we   = 1'b0;
        model[a] = d;
        settled  = 1'b1;
    endtask

    // Shift nb bits of tx MSB first; host samples miso just before each rise.
    // With inj set, a local write is timed to land on the same clk as the
    // target's write of this byte (SYNC flops + one edge-detect cycle).
    task automatic xfer_bits(input logic [7:0] tx, input int nb, input bit inj,
                             input logic [3:0] la, input logic [7:0] ld,
                             output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nb; i--) begin
            bus.spi_mosi = tx[i];
            tick(HALF);
            rx[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            if (inj && i == 0) begin
                tick(SYNC);
                lcl_we    = 1'b1;
                lcl_addr  = la;
                lcl_wdata = ld;
                tick(1);
                lcl_we = 1'b0;
                tick(HALF - SYNC - 1);
            end else begin
                tick(HALF);
            end
            bus.spi_sclk = 1'b0;
        end
        tick(HALF);
    endtask

    task automatic cs_start(input bit live);
        settled      = 1'b0;
        bus.spi_cs_n = 1'b0;
        tick(HALF);
        exp_oe  = live;
        settled = 1'b1;
    endtask

    task automatic cs_end(input bit wrote);
        settled      = 1'b0;
        bus.spi_cs_n = 1'b1;
        tick(HALF);
        exp_oe = 1'b0;
        if (wrote) irq_exp++;
`ifdef SPI_TGT_IRQ_EN
        check("wr_irq_count", FW'(irq_seen), FW'(irq_exp));
`endif
        settled = 1'b1;
    endtask

    task automatic frame(input int nbytes, input int inj_byte,
                         input logic [3:0] la, input logic [7:0] ld);
        logic [3:0] a;
        logic [7:0] rxb;
        bit         rw;
        bit         wrote;
        wrote = 1'b0;
        cs_start(1'b1);
        rw = tx_buf[0][7];
        a  = tx_buf[0][3:0];
        for (int b = 0; b < nbytes; b++) begin
            settled = 1'b0;
            xfer_bits(tx_buf[b], 8, b == inj_byte, la, ld, rxb);
            rx_buf[b] = rxb;
            if (b > 0) begin
                if (rw) begin
                    check("rd_byte", FW'(rxb), FW'(model[a]));
                end else begin
                    if (b == inj_byte) model[la] = ld;
                    model[a] = tx_buf[b];
                    wrote    = 1'b1;
                end
                a = a + 4'd1;
            end
            tick(2);
            settled = 1'b1;
            tick(2);
        end
        cs_end(wrote);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rxb;
        int         n;

        rst          = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        lcl_we       = 1'b0;
        lcl_addr     = '0;
        lcl_wdata    = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        tick(3);
        check("rst_regs", regs_o, '0);
        check("rst_oe", FW'(bus.spi_miso_oe), '0);
        check("rst_miso", FW'(bus.spi_miso), '0);
`ifdef SPI_TGT_IRQ_EN
        check("rst_irq", FW'(wr_irq), '0);
`endif
        rst = 1'b0;
        tick(SYNC + 4);
        settled = 1'b1;
        tick(2);

        // Basic write of two bytes at 3
        tx_buf[0] = 8'h03; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h5A;
        frame(3, -1, 4'd0, 8'h00);
        check("wr_basic", regs_o, 128'h00000000_00000000_0000005A_A5000000);

        // Address wrap 15 -> 0
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        frame(3, -1, 4'd0, 8'h00);
        check("wrap_reg15", FW'(regs_o[127:120]), FW'(8'h11));
        check("wrap_reg0", FW'(regs_o[7:0]), FW'(8'h22));

        // Preloaded read, auto-increment
        lcl_write(4'd2, 8'hC3);
        lcl_write(4'd3, 8'h3C);
        tx_buf[0] = 8'h82; tx_buf[1] = 8'h00; tx_buf[2] = 8'hFF;
        frame(3, -1, 4'd0, 8'h00);
        check("rd_first", FW'(rx_buf[1]), FW'(8'hC3));
        check("rd_second", FW'(rx_buf[2]), FW'(8'h3C));
        check("rd_oe_after", FW'(bus.spi_miso_oe), '0);

        // Partial command discarded, then a clean frame
        cs_start(1'b1);
        settled = 1'b0;
        xfer_bits(8'h01, 5, 1'b0, 4'd0, 8'h00, rxb);
        tick(2);
        settled = 1'b1;
        cs_end(1'b0);
        check("partial_reg1", FW'(regs_o[15:8]), '0);
        check("partial_idle", FW'(bus.spi_miso_oe), '0);
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h77;
        frame(2, -1, 4'd0, 8'h00);
        check("after_partial_reg1", FW'(regs_o[15:8]), FW'(8'h77));

        // Same-cycle local and SPI writes
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h44;
        frame(2, 1, 4'd5, 8'hEE);
        check("clash_same_reg5", FW'(regs_o[47:40]), FW'(8'h44));
        lcl_write(4'd5, 8'h00);
        frame(2, 1, 4'd6, 8'hEE);
        check("clash_diff_reg5", FW'(regs_o[47:40]), FW'(8'h44));
        check("clash_diff_reg6", FW'(regs_o[55:48]), FW'(8'hEE));

        // Randomized frames interleaved with local writes
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1)
                lcl_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            n = $urandom_range(2, 4);
            for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
            frame(n, -1, 4'd0, 8'h00);
            tick($urandom_range(1, 6));
        end

        // Reset in the middle of a read frame
        cs_start(1'b1);
        settled = 1'b0;
        xfer_bits(8'h80, 8, 1'b0, 4'd0, 8'h00, rxb);
        xfer_bits(8'h00, 3, 1'b0, 4'd0, 8'h00, rxb);
        rst = 1'b1;
        tick(2);
        check("midrst_regs", regs_o, '0);
        check("midrst_oe", FW'(bus.spi_miso_oe), '0);
        check("midrst_miso", FW'(bus.spi_miso), '0);
`ifdef SPI_TGT_IRQ_EN
        check("midrst_irq", FW'(wr_irq), '0);
`endif
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        exp_oe = 1'b0;
        rst    = 1'b0;
        tick(SYNC + 4);
        settled = 1'b1;

        // CS still low from before reset: traffic must be ignored
        xfer_bits(8'h05, 8, 1'b0, 4'd0, 8'h00, rxb);
        xfer_bits(8'h99, 8, 1'b0, 4'd0, 8'h00, rxb);
        check("stale_cs_oe", FW'(bus.spi_miso_oe), '0);
        check("stale_cs_regs", regs_o, '0);
        cs_end(1'b0);
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h99;
        frame(2, -1, 4'd0, 8'h00);
        check("rearmed_reg5", FW'(regs_o[47:40]), FW'(8'h99));

        tick(4);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
